mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  EX/MEM pipeline register plus data-memory access sequencer for the 5-stage MIPS core.
//  Consumes the EXE stage results (ALUOutE, WriteDataE, WriteRegE) and the E-stage control bits.
//  Drives a req/ack data-memory bus and stalls the pipeline while an access is outstanding.
//  Presents per-instruction completion (CommitM) to the MEM/WB register, and ALUOutM/WriteRegM/RegWriteM for forwarding.
// PARAMETERS
//  TIMEOUT  16  cycles in ACCESS without dmem_ack before forced error completion; 0 = never; range 0..255
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  ValidE       in   1   E stage holds a real instruction (0 = bubble)
//  RegWriteE    in   1   instruction writes the register file
//  MemtoRegE    in   1   load: WB result comes from memory
//  MemWriteE    in   1   store
//  ALUOutE      in   32  ALU result / effective address
//  WriteDataE   in   32  forwarded store data
//  WriteRegE    in   5   destination register
//  FlushM       in   1   load a bubble instead of the E-stage contents
//  ALUOutM      out  32  registered ALUOutE (forwarding source, bus address)
//  WriteDataM   out  32  registered WriteDataE
//  WriteRegM    out  5   registered WriteRegE
//  RegWriteM    out  1   registered RegWriteE & ValidE (for the hazard unit)
//  MemtoRegM    out  1   registered MemtoRegE
//  ReadDataM    out  32  dmem_rdata when a load completes with ack, else 0
//  CommitM      out  1   the M-stage instruction completes this cycle
//  WbRegWriteM  out  1   RegWriteM & CommitM & ~ErrM
//  ErrM         out  2   valid with CommitM: 00 ok, 01 misaligned, 10 timeout
//  StallM       out  1   hold the IF/ID/EX stages and do not update the EX/MEM register
//  dmem_req     out  1   bus request
//  dmem_we      out  1   1 = write
//  dmem_addr    out  32  = ALUOutM
//  dmem_wdata   out  32  = WriteDataM
//  dmem_ack     in   1   access done this cycle (may arrive in the same cycle as req)
//  dmem_rdata   in   32  read data, valid when dmem_ack
// BEHAVIOUR
//  Reset: all registered outputs 0, state IDLE, timeout counter 0; dmem_req drops immediately, including mid-access.
//  MemOp = ValidM & (MemtoRegM | MemWriteM).
//    Misaligned = MemOp & (ALUOutM[1:0] != 0).
//  EX/MEM register updates on every edge where StallM = 0.
//    - FlushM = 1: loads a bubble (ValidM = 0, all control bits 0; data fields don't-care).
//    - FlushM = 0: loads the E-stage inputs.
//    - FlushM is ignored while StallM = 1; the hazard unit must not flush M during a stall.
//  States:
//    IDLE: M holds a bubble, an ALU op, or a misaligned mem op.
//      - CommitM = ValidM.
//      - ErrM = 01 if Misaligned, else 00.
//      - dmem_req = 0 and StallM = 0.
//    ACCESS: M holds an aligned mem op.
//      - dmem_req = 1, dmem_we = MemWriteM.
//      - StallM = ~dmem_ack & ~timeout_hit.
//      - CommitM = dmem_ack | timeout_hit.
//      - ErrM = 10 if timeout_hit & ~dmem_ack, else 00.
//  Transitions, on an edge with StallM = 0: next state is ACCESS if the newly captured instruction is an aligned mem op, else IDLE.
//  Timeout:
//    - The counter clears when ACCESS is entered and increments each ACCESS cycle without ack.
//    - timeout_hit = (TIMEOUT != 0) & (count == TIMEOUT - 1).
//    - A timeout completes the instruction with ReadDataM = 0.
//    - A late ack after a timeout belongs to no instruction; the bus must not send one.
//  Ack has priority over timeout in the same cycle.
//  Latency:
//    - ALU op or bubble: one cycle in M.
//    - Mem op with zero-wait ack: one cycle, no stall.
//    - Mem op with N wait cycles: N + 1 cycles, StallM high for N cycles.
//  Back-to-back mem ops re-enter ACCESS with the counter cleared; dmem_req may stay high across the boundary.
//  A store never writes back: RegWriteE is expected to be 0; WbRegWriteM follows RegWriteM regardless.
// TESTING
//  - ALU op: ValidE=1, RegWriteE=1, ALUOutE=0x1234, WriteRegE=5. Next cycle: CommitM=1, WbRegWriteM=1, ALUOutM=0x1234, WriteRegM=5, dmem_req=0.
//  - Load at 0x100, ack 2 cycles after req, rdata=0xDEADBEEF. Expect: dmem_req 3 cycles, StallM=1 for 2 cycles, then CommitM=1, ReadDataM=0xDEADBEEF.
//  - Store at 0x200, data 0xCAFE, zero-wait ack. Expect: dmem_we=1, dmem_wdata=0xCAFE, StallM never set, CommitM=1, WbRegWriteM=0.
//  - Load at 0x102. Expect: no dmem_req, CommitM=1, ErrM=01, WbRegWriteM=0.
//  - TIMEOUT=4, load, never ack. Expect: StallM=1 for 3 cycles, 4th cycle CommitM=1, ErrM=10, ReadDataM=0, then IDLE.
//  - rst_n low during ACCESS. Expect: dmem_req, StallM, CommitM=0 at once; after release, a new load runs normally; FlushM asserted during a stall has no effect.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// req/we/addr/wdata are driven by the master. The slave answers with ack and rdata.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// EX/MEM pipeline register and data-memory access sequencer for the 5-stage MIPS core.
// The M-stage instruction goes to ACCESS only when it is an aligned load or store.
// The pipeline stalls in ACCESS until the bus acks or the timeout counter expires.
// Misaligned memory ops and non-memory ops complete in one cycle without touching the bus.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16   // ACCESS cycles without ack before a forced error; 0 = never
) (
  input  logic        clk,
  input  logic        rst_n,
  // E-stage results and control
  input  logic        ValidE,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic [31:0] ALUOutE,
  input  logic [31:0] WriteDataE,
  input  logic [4:0]  WriteRegE,
  input  logic        FlushM,
  // M-stage outputs
  output logic [31:0] ALUOutM,
  output logic [31:0] WriteDataM,
  output logic [4:0]  WriteRegM,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic [31:0] ReadDataM,
  output logic        CommitM,
  output logic        WbRegWriteM,
  output logic [1:0]  ErrM,
  output logic        StallM,
  // data-memory bus
  mem_stage_if.master dmem
);

  typedef enum logic {
    IDLE   = 1'b0,  // M holds a bubble, an ALU op or a misaligned mem op
    ACCESS = 1'b1   // M holds an aligned mem op that is on the bus
  } stateT;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  // Last count value before a timeout fires. The value has no meaning when TIMEOUT is 0.
  localparam logic [7:0] TIMEOUT_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  stateT       state;
  stateT       nextState;
  logic        validM;
  logic        memWriteM;
  logic [7:0]  timeoutCount;

  logic        memOpM;
  logic        misalignedM;
  logic        timeoutHit;
  logic        captureAlignedMemOp;
  logic        busReq;
  logic        busWe;

  // Decode the M-stage instruction and the instruction that the next edge would capture.
  assign memOpM      = validM & (MemtoRegM | memWriteM);
  assign misalignedM = memOpM & (ALUOutM[1:0] != 2'b00);

  // A flushed capture is a bubble, so a flushed instruction never starts a bus access.
  assign captureAlignedMemOp = ~FlushM & ValidE & (MemtoRegE | MemWriteE)
                             & (ALUOutE[1:0] == 2'b00);

  assign timeoutHit = (TIMEOUT != 0) && (state == ACCESS) && (timeoutCount == TIMEOUT_LAST);

  // The bus address and write data come straight from the EX/MEM register.
  assign dmem.dmem_req   = busReq;
  assign dmem.dmem_we    = busWe;
  assign dmem.dmem_addr  = ALUOutM;
  assign dmem.dmem_wdata = WriteDataM;

  // A result reaches the register file only when it commits without an error.
  assign WbRegWriteM = RegWriteM & CommitM & (ErrM == ERR_OK);

  // EX/MEM register: load the E stage (or a bubble on flush) whenever M is not stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      validM     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      memWriteM  <= 1'b0;
      ALUOutM    <= 32'd0;
      WriteDataM <= 32'd0;
      WriteRegM  <= 5'd0;
    end else if (!StallM) begin
      if (FlushM) begin
        validM    <= 1'b0;
        RegWriteM <= 1'b0;
        MemtoRegM <= 1'b0;
        memWriteM <= 1'b0;
      end else begin
        validM    <= ValidE;
        RegWriteM <= RegWriteE & ValidE;
        MemtoRegM <= MemtoRegE;
        memWriteM <= MemWriteE;
      end
      // The data fields are don't-care for a bubble, so they load unconditionally.
      ALUOutM    <= ALUOutE;
      WriteDataM <= WriteDataE;
      WriteRegM  <= WriteRegE;
    end
  end

  // Sequencer state register. Reset drops dmem_req at once, even in the middle of an access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Timeout counter: cleared whenever M advances, counts each stalled ACCESS cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeoutCount <= 8'd0;
    end else if (!StallM) begin
      timeoutCount <= 8'd0;
    end else begin
      timeoutCount <= timeoutCount + 8'd1;
    end
  end

  // Next-state and M-stage outputs. An ack wins over a timeout in the same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path infers a latch.
    nextState = state;
    busReq    = 1'b0;
    busWe     = 1'b0;
    StallM    = 1'b0;
    CommitM   = 1'b0;
    ErrM      = ERR_OK;
    ReadDataM = 32'd0;

    unique case (state)
      IDLE: begin
        CommitM = validM;
        if (misalignedM) begin
          ErrM = ERR_MISALIGN;
        end
      end
      ACCESS: begin
        busReq  = 1'b1;
        busWe   = memWriteM;
        StallM  = ~dmem.dmem_ack & ~timeoutHit;
        CommitM = dmem.dmem_ack | timeoutHit;
        if (timeoutHit && !dmem.dmem_ack) begin
          ErrM = ERR_TIMEOUT;
        end
        if (dmem.dmem_ack && MemtoRegM) begin
          ReadDataM = dmem.dmem_rdata;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase

    // The state follows the instruction that M captures on this edge.
    if (!StallM) begin
      nextState = captureAlignedMemOp ? ACCESS : IDLE;
    end
  end

endmodule
